// File: rtl/tt_sel_ctrl.sv
// Design-select controller: synchronises the select pads, counts inc edges into a saturating
// address and latches it with a qualified enable. Optional inc deglitch: TT_SEL_DEGLITCH_EN.
module tt_sel_ctrl #(
  parameter int G_X    = 16,
  parameter int G_Y    = 16,
  parameter int SYNC_N = 2,
  parameter int DG_LEN = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  pad_sel_rst_n,
  input  logic                                  pad_sel_inc,
  input  logic                                  pad_ena,
  output logic [$clog2(G_X)+$clog2(G_Y)-1:0]    sel_addr,
  output logic [$clog2(G_Y)-1:0]                sel_mux,
  output logic [$clog2(G_X)-1:0]                sel_blk,
  output logic                                  sel_ena,
  output logic [$clog2(G_X)+$clog2(G_Y)-1:0]    sel_cnt,
  output logic                                  sel_ovf
);

  // state  | meaning
  // IDLE   | selection held in reset, all outputs 0
  // COUNT  | inc edges advance sel_cnt, waiting for an ena rising edge
  // ACTIVE | sel_addr latched and enabled, inc edges still advance sel_cnt
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam int BW  = $clog2(G_X);
  localparam int YW  = $clog2(G_Y);
  localparam int AW  = BW + YW;
  localparam int N_D = G_X * G_Y;
  localparam logic [AW-1:0] CNT_MAX = AW'(N_D - 1);

  if (G_X < 2 || (G_X & (G_X - 1)) != 0 || G_Y < 2 || (G_Y & (G_Y - 1)) != 0 ||
      SYNC_N < 2 || DG_LEN < 2) begin : g_bad_param
    $error("tt_sel_ctrl: illegal parameter set");
  end

  logic [SYNC_N-1:0] rst_sync, inc_sync, ena_sync;
  logic              sync_sel_rst_n, sync_inc, sync_ena;
  logic              inc_lvl, inc_d, ena_d;
  logic              inc_edge, ena_rise;
  logic [1:0]        state;
  logic [AW-1:0]     cnt_nxt;
  logic              ovf_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_sync <= '0;
      inc_sync <= '0;
      ena_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[SYNC_N-2:0], pad_sel_rst_n};
      inc_sync <= {inc_sync[SYNC_N-2:0], pad_sel_inc};
      ena_sync <= {ena_sync[SYNC_N-2:0], pad_ena};
    end
  end

  assign sync_sel_rst_n = rst_sync[SYNC_N-1];
  assign sync_inc       = inc_sync[SYNC_N-1];
  assign sync_ena       = ena_sync[SYNC_N-1];

`ifdef TT_SEL_DEGLITCH_EN
  localparam int DW = $clog2(DG_LEN);
  localparam logic [DW-1:0] DG_LOAD = DW'(DG_LEN - 1);
  logic [DW-1:0] dg_tmr;
  logic          inc_filt;

  // The filtered level follows sync_inc only after DG_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dg_tmr   <= DG_LOAD;
      inc_filt <= 1'b0;
    end else if (sync_inc == inc_filt) begin
      dg_tmr <= DG_LOAD;
    end else if (dg_tmr == '0) begin
      dg_tmr   <= DG_LOAD;
      inc_filt <= sync_inc;
    end else begin
      dg_tmr <= dg_tmr - 1'b1;
    end
  end

  assign inc_lvl = inc_filt;
`else
  assign inc_lvl = sync_inc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_d <= 1'b0;
      ena_d <= 1'b0;
    end else begin
      inc_d <= inc_lvl;
      ena_d <= sync_ena;
    end
  end

  assign inc_edge = inc_lvl & ~inc_d;
  assign ena_rise = sync_ena & ~ena_d;

  always_comb begin
    cnt_nxt = sel_cnt;
    ovf_nxt = sel_ovf;
    if (inc_edge) begin
      if (sel_cnt == CNT_MAX) ovf_nxt = 1'b1;
      else                    cnt_nxt = sel_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !sync_sel_rst_n) begin
      state    <= ST_IDLE;
      sel_cnt  <= '0;
      sel_ovf  <= 1'b0;
      sel_addr <= '0;
      sel_ena  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_COUNT;
        ST_COUNT: begin
          sel_cnt <= cnt_nxt;
          sel_ovf <= ovf_nxt;
          // Latch the post-increment count so a coincident inc edge is included.
          if (ena_rise) begin
            sel_addr <= cnt_nxt;
            sel_ena  <= 1'b1;
            state    <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          sel_cnt <= cnt_nxt;
          sel_ovf <= ovf_nxt;
          if (!sync_ena) begin
            sel_ena <= 1'b0;
            state   <= ST_COUNT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sel_mux = sel_addr[AW-1:BW];
  assign sel_blk = sel_addr[BW-1:0];

endmodule
